// File: rtl/noc_arb_pkg.sv
// Shared types for the NoC agent arbiter: agent tags, FSM states and the
// request record carried onto the NoC port.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    AGENT_CPU = 2'd0,
    AGENT_IO  = 2'd1
  } agent_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    THROTTLE
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    agent_e      agent;
  } noc_req_t;

  // Width of the same-owner grant streak counter (saturates).
  localparam int RUN_W = 4;

  function automatic agent_e other_agent(agent_e a);
    return (a == AGENT_CPU) ? AGENT_IO : AGENT_CPU;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for the downstream buffer: consumes on NoC handshake, refills
// on credit_return, and flags a sticky error on a return while already full.
module noc_credit_counter #(
  parameter int NUM_CREDITS = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_consume,
  input  logic                             i_return,
  output logic [$clog2(NUM_CREDITS+1)-1:0] o_credits,
  output logic                             o_err
);

  localparam int CW = $clog2(NUM_CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_CREDITS);

  logic [CW-1:0] r_credits;
  logic          r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= FULL;
      r_err     <= 1'b0;
    end else begin
      // Simultaneous consume and return cancel out, even when full.
      case ({i_consume, i_return})
        2'b10: if (r_credits != '0) r_credits <= r_credits - 1'b1;
        2'b01: begin
          if (r_credits == FULL) r_err <= 1'b1;
          else                   r_credits <= r_credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_credits = r_credits;
  assign o_err     = r_err;

endmodule

// File: rtl/noc_agent_arbiter.sv
// Weighted round-robin arbiter sharing the NoC request port between CPU and IO,
// credit-gated and power-throttled. Define NOC_ARB_STATS_EN for grant counters.
module noc_agent_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_CREDITS  = 8,
  parameter int CPU_WEIGHT   = 3,
  parameter int IO_WEIGHT    = 1,
  parameter int THROTTLE_GAP = 20
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req_valid,
  input  logic                             cpu_req_wr,
  input  logic [31:0]                      cpu_req_addr,
  output logic                             cpu_req_ready,
  input  logic                             io_req_valid,
  input  logic                             io_req_wr,
  input  logic [31:0]                      io_req_addr,
  output logic                             io_req_ready,
  output logic                             noc_req_valid,
  output logic                             noc_req_wr,
  output logic [31:0]                      noc_req_addr,
  output logic [1:0]                       noc_req_agent,
  input  logic                             noc_req_ready,
  input  logic                             credit_return,
  input  logic                             power_limit_threshold,
  output logic [$clog2(NUM_CREDITS+1)-1:0] credits_avail,
  output logic                             throttle_active,
  output logic                             credit_err,
  output logic [31:0]                      grant_cnt_cpu,
  output logic [31:0]                      grant_cnt_io
);

  localparam int CW    = $clog2(NUM_CREDITS + 1);
  localparam int GAP_W = (THROTTLE_GAP > 1) ? $clog2(THROTTLE_GAP) : 1;

  arb_state_e       r_state;
  noc_req_t         r_req;
  logic             r_valid;
  agent_e           r_last;
  logic [RUN_W-1:0] r_run;
  logic [GAP_W-1:0] r_gap;
  logic             r_live;

  logic             w_both;
  logic             w_keep;
  logic             w_grant;
  logic             w_hs;
  int               w_weight;
  agent_e           w_winner;
  noc_req_t         w_sel;
  logic [CW-1:0]    w_credits;

  // A zero streak only exists straight out of reset, so the other agent
  // (CPU, since last_owner resets to IO) takes the first contention.
  always_comb begin
    w_weight = (r_last == AGENT_CPU) ? CPU_WEIGHT : IO_WEIGHT;
    w_keep   = (r_run != '0) && (int'(r_run) < w_weight);
    w_both   = cpu_req_valid && io_req_valid;
    w_winner = AGENT_CPU;
    if (w_both)             w_winner = w_keep ? r_last : other_agent(r_last);
    else if (!cpu_req_valid) w_winner = AGENT_IO;
    w_sel.agent = w_winner;
    w_sel.addr  = (w_winner == AGENT_CPU) ? cpu_req_addr : io_req_addr;
    w_sel.wr    = (w_winner == AGENT_CPU) ? cpu_req_wr   : io_req_wr;
  end

  // r_live keeps the ready outputs quiet while reset is held.
  assign w_grant = r_live && (r_state == IDLE) && (cpu_req_valid || io_req_valid)
                   && (w_credits != '0);
  assign w_hs    = r_valid && noc_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_valid <= 1'b0;
      r_last  <= AGENT_IO;
      r_run   <= '0;
      r_gap   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_req   <= w_sel;
            r_valid <= 1'b1;
            r_state <= SEND;
            r_last  <= w_winner;
            if (w_winner == r_last) r_run <= (r_run == '1) ? r_run : r_run + 1'b1;
            else                    r_run <= RUN_W'(1);
          end
        end
        SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (power_limit_threshold && (THROTTLE_GAP > 0)) begin
              r_state <= THROTTLE;
              r_gap   <= GAP_W'(THROTTLE_GAP - 1);
            end else begin
              r_state <= IDLE;
            end
          end
        end
        THROTTLE: begin
          if (r_gap == '0) r_state <= IDLE;
          else             r_gap   <= r_gap - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  noc_credit_counter #(
    .NUM_CREDITS(NUM_CREDITS)
  ) u_credits (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_consume (w_hs),
    .i_return  (credit_return),
    .o_credits (w_credits),
    .o_err     (credit_err)
  );

  assign cpu_req_ready   = w_grant && (w_winner == AGENT_CPU);
  assign io_req_ready    = w_grant && (w_winner == AGENT_IO);
  assign noc_req_valid   = r_valid;
  assign noc_req_wr      = r_req.wr;
  assign noc_req_addr    = r_req.addr;
  assign noc_req_agent   = r_req.agent;
  assign credits_avail   = w_credits;
  assign throttle_active = (r_state == THROTTLE);

`ifdef NOC_ARB_STATS_EN
  logic [31:0] r_cnt_cpu;
  logic [31:0] r_cnt_io;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_cpu <= '0;
      r_cnt_io  <= '0;
    end else begin
      if (cpu_req_ready && (r_cnt_cpu != '1)) r_cnt_cpu <= r_cnt_cpu + 1'b1;
      if (io_req_ready  && (r_cnt_io  != '1)) r_cnt_io  <= r_cnt_io  + 1'b1;
    end
  end

  assign grant_cnt_cpu = r_cnt_cpu;
  assign grant_cnt_io  = r_cnt_io;
`else
  assign grant_cnt_cpu = '0;
  assign grant_cnt_io  = '0;
`endif

endmodule
